// File: rtl/tempstat_pkg.sv
// rtl/tempstat_pkg.sv - shared types and constants for the temperature status supervisor
package tempstat_pkg;

    typedef enum logic [1:0] {
        S_COLD   = 2'd0,
        S_HEAT   = 2'd1,
        S_SETTLE = 2'd2,
        S_READY  = 2'd3
    } state_t;

    localparam logic [3:0] DROP_CNT_MAX = 4'd15;

endpackage

// File: rtl/mdl_settle_cnt.sv
// rtl/mdl_settle_cnt.sv - enable-gated clearable settle counter with terminal-count flags
module mdl_settle_cnt #(
    parameter int WARMUP_TICKS = 4096,
    parameter int CNT_W        = 13
) (
    input  logic i_MCLK,
    input  logic i_RST,
    input  logic clr,
    input  logic inc,
    output logic term,
    output logic done
);

    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(WARMUP_TICKS - 1);
    localparam logic [CNT_W-1:0] DONE_VAL = CNT_W'(WARMUP_TICKS);

    logic [CNT_W-1:0] cnt;

    // term flags the increment that completes the settle; done covers a
    // completion that landed between FSM enables
    assign term = inc && (cnt == LAST_VAL);
    assign done = (cnt == DONE_VAL);

    always_ff @(posedge i_MCLK) begin
        if (i_RST) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !done) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mdl_tempstat.sv
// rtl/mdl_tempstat.sv - temperature drop flag/count/interrupt and heater warm-up supervisor
module mdl_tempstat
    import tempstat_pkg::*;
#(
    parameter int WARMUP_TICKS = 4096,
    parameter int CNT_W        = 13
) (
    input  logic       i_MCLK,
    input  logic       i_RST,
    input  logic       i_CLK4M_PCEN_n,
    input  logic       i_CLK2M_PCEN_n,
    input  logic       i_CLK2M_STOP_n,
    input  logic       i_TEMPDROP_SET_n,
    input  logic       i_HEATEN_n,
    input  logic       i_TEMPDROP_CLR,
    input  logic       i_IRQ_EN,
    output logic       o_TEMPDROP,
    output logic [3:0] o_DROP_CNT,
    output logic       o_IRQ_n,
    output logic       o_HEATER_ON,
    output logic       o_WARMING,
    output logic       o_READY
);

    state_t state, state_nx;
    logic   cnt_clr;
    logic   cnt_inc;
    logic   cnt_term;
    logic   cnt_done;
    logic   en4;
    logic   drop;

    assign en4     = !i_CLK4M_PCEN_n;
    assign drop    = !i_TEMPDROP_SET_n;
    assign cnt_inc = !i_CLK2M_PCEN_n && i_CLK2M_STOP_n && (state == S_SETTLE);

    mdl_settle_cnt #(
        .WARMUP_TICKS (WARMUP_TICKS),
        .CNT_W        (CNT_W)
    ) u_settle_cnt (
        .i_MCLK (i_MCLK),
        .i_RST  (i_RST),
        .clr    (cnt_clr),
        .inc    (cnt_inc),
        .term   (cnt_term),
        .done   (cnt_done)
    );

    always_ff @(posedge i_MCLK) begin
        if (i_RST) begin
            state <= S_COLD;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_clr  = 1'b0;
        if (en4) begin
            case (state)
                S_COLD: begin
                    if (!i_HEATEN_n) begin
                        state_nx = S_HEAT;
                    end else begin
                        state_nx = S_SETTLE;
                        cnt_clr  = 1'b1;
                    end
                end
                S_HEAT: begin
                    if (i_HEATEN_n) begin
                        state_nx = S_SETTLE;
                        cnt_clr  = 1'b1;
                    end
                end
                S_SETTLE: begin
                    // heater demand beats a completion in the same cycle
                    if (!i_HEATEN_n) begin
                        state_nx = S_HEAT;
                    end else if (cnt_done || cnt_term) begin
                        state_nx = S_READY;
                    end
                end
                S_READY: begin
                    if (!i_HEATEN_n) begin
                        state_nx = S_HEAT;
                    end else if (drop) begin
                        state_nx = S_SETTLE;
                        cnt_clr  = 1'b1;
                    end
                end
                default: state_nx = S_COLD;
            endcase
        end
    end

    always_ff @(posedge i_MCLK) begin
        if (i_RST) begin
            o_TEMPDROP  <= 1'b0;
            o_DROP_CNT  <= 4'd0;
            o_HEATER_ON <= 1'b0;
        end else if (en4) begin
            o_HEATER_ON <= !i_HEATEN_n;
            // a drop seen together with a clear restarts the count at one
            if (drop) begin
                o_TEMPDROP <= 1'b1;
                if (i_TEMPDROP_CLR) begin
                    o_DROP_CNT <= 4'd1;
                end else if (o_DROP_CNT != DROP_CNT_MAX) begin
                    o_DROP_CNT <= o_DROP_CNT + 4'd1;
                end
            end else if (i_TEMPDROP_CLR) begin
                o_TEMPDROP <= 1'b0;
                o_DROP_CNT <= 4'd0;
            end
        end
    end

    assign o_IRQ_n   = !(o_TEMPDROP && i_IRQ_EN);
    assign o_WARMING = (state == S_HEAT) || (state == S_SETTLE);
    assign o_READY   = (state == S_READY);

endmodule

// File: tb/tb_mdl_tempstat.sv
// tb/tb_mdl_tempstat.sv - self-checking bench for mdl_tempstat against a behavioural model
module tb_mdl_tempstat;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pcen4_n = 1'b1;
    logic       pcen2_n = 1'b1;
    logic       stop_n = 1'b1;
    logic       set_n = 1'b1;
    logic       heaten_n = 1'b1;
    logic       clr = 1'b0;
    logic       irq_en = 1'b0;
    logic       tempdrop;
    logic [3:0] drop_cnt;
    logic       irq_n;
    logic       heater_on;
    logic       warming;
    logic       ready;

    mdl_tempstat #(.WARMUP_TICKS(W), .CNT_W(4)) dut (
        .i_MCLK           (clk),
        .i_RST            (rst),
        .i_CLK4M_PCEN_n   (pcen4_n),
        .i_CLK2M_PCEN_n   (pcen2_n),
        .i_CLK2M_STOP_n   (stop_n),
        .i_TEMPDROP_SET_n (set_n),
        .i_HEATEN_n       (heaten_n),
        .i_TEMPDROP_CLR   (clr),
        .i_IRQ_EN         (irq_en),
        .o_TEMPDROP       (tempdrop),
        .o_DROP_CNT       (drop_cnt),
        .o_IRQ_n          (irq_n),
        .o_HEATER_ON      (heater_on),
        .o_WARMING        (warming),
        .o_READY          (ready)
    );

    always #5 clk = ~clk;

    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    bit  rand_mode = 0;
    bit  last_e2 = 0;

    // model: mode 0 cold, 1 heating, 2 settling, 3 ready; rem = ticks still owed
    int  m_mode = 0;
    int  m_rem = 0;
    bit  m_flag = 0;
    int  m_cnt = 0;
    bit  m_heat = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_edge(input bit e4, input bit e2);
        bit d;
        if (rst) begin
            m_mode = 0; m_rem = 0; m_flag = 0; m_cnt = 0; m_heat = 0;
        end else begin
            if (e2 && stop_n && m_mode == 2 && m_rem > 0) m_rem--;
            if (e4) begin
                d = !set_n;
                if (d) begin
                    m_flag = 1;
                    m_cnt = clr ? 1 : ((m_cnt < 15) ? m_cnt + 1 : 15);
                end else if (clr) begin
                    m_flag = 0;
                    m_cnt = 0;
                end
                m_heat = !heaten_n;
                case (m_mode)
                    0: if (!heaten_n) m_mode = 1; else begin m_mode = 2; m_rem = W; end
                    1: if (heaten_n) begin m_mode = 2; m_rem = W; end
                    2: if (!heaten_n) m_mode = 1; else if (m_rem == 0) m_mode = 3;
                    default: if (!heaten_n) m_mode = 1; else if (d) begin m_mode = 2; m_rem = W; end
                endcase
            end
        end
    endtask

    task automatic step();
        bit e4, e2;
        if (rand_mode) begin
            e4 = ($urandom % 3) == 0;
            e2 = ($urandom % 5) == 0;
        end else begin
            e4 = (cyc % 4) == 0;
            e2 = (cyc % 8) == 0;
        end
        pcen4_n = !e4;
        pcen2_n = !e2;
        @(posedge clk);
        model_edge(e4, e2);
        last_e2 = e2;
        cyc++;
        #1;
        tests++;
        if (tempdrop !== m_flag || drop_cnt !== 4'(m_cnt) || irq_n !== !(m_flag && irq_en) ||
            heater_on !== m_heat || warming !== (m_mode == 1 || m_mode == 2) || ready !== (m_mode == 3)) begin
            fails++;
            $display("FAIL model cycle %0d: got flag=%0b cnt=%0d irq_n=%0b heat=%0b warm=%0b rdy=%0b expected flag=%0b cnt=%0d irq_n=%0b heat=%0b warm=%0b rdy=%0b",
                     cyc, tempdrop, drop_cnt, irq_n, heater_on, warming, ready,
                     m_flag, m_cnt, !(m_flag && irq_en), m_heat, (m_mode == 1 || m_mode == 2), (m_mode == 3));
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_settle();
        int k = 0;
        step();
        while (!(warming && !heater_on && !ready) && k < 200) begin
            step();
            k++;
        end
        if (k >= 200) check("settle_timeout", 0, 1);
    endtask

    task automatic run_ticks(input int n);
        int t = 0;
        int k = 0;
        while (t < n && k < 500) begin
            step();
            if (last_e2) t++;
            k++;
        end
    endtask

    task automatic wait_ready(output int total);
        int k = 0;
        total = 0;
        while (!ready && k < 600) begin
            step();
            if (last_e2) total++;
            k++;
        end
        if (!ready) check("ready_timeout", 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tempdrop"}, int'(tempdrop), 0);
        check({tag, "_cnt"}, int'(drop_cnt), 0);
        check({tag, "_irq_n"}, int'(irq_n), 1);
        check({tag, "_heater"}, int'(heater_on), 0);
        check({tag, "_warming"}, int'(warming), 0);
        check({tag, "_ready"}, int'(ready), 0);
    endtask

    initial begin
        int t;

        // 1: power-up with heater off
        rst = 1;
        steps(3);
        check_reset_outputs("reset");
        rst = 0;
        wait_settle();
        wait_ready(t);
        check("s1_ticks", t, 8);

        // 2: heater on for 10 CLK4M periods then released
        heaten_n = 0;
        steps(40);
        check("s2_heater_on", int'(heater_on), 1);
        check("s2_warming", int'(warming), 1);
        check("s2_ready", int'(ready), 0);
        heaten_n = 1;
        wait_settle();
        wait_ready(t);
        check("s2_ticks", t, 8);

        // 3: CLK2M stopped for 3 ticks mid-settle
        heaten_n = 0;
        steps(8);
        heaten_n = 1;
        wait_settle();
        run_ticks(3);
        stop_n = 0;
        run_ticks(3);
        stop_n = 1;
        wait_ready(t);
        check("s3_ticks", t + 6, 11);

        // 4: 17 drops saturate the count, then clear
        irq_en = 1;
        for (int i = 0; i < 17; i++) begin
            set_n = 0;
            steps(4);
            set_n = 1;
            steps(4);
        end
        check("s4_cnt", int'(drop_cnt), 15);
        check("s4_flag", int'(tempdrop), 1);
        check("s4_irq_n", int'(irq_n), 0);
        clr = 1;
        steps(4);
        clr = 0;
        check("s4_clr_cnt", int'(drop_cnt), 0);
        check("s4_clr_flag", int'(tempdrop), 0);
        check("s4_clr_irq_n", int'(irq_n), 1);

        // 5: drop and clear together
        steps(2);
        set_n = 0;
        clr = 1;
        steps(4);
        set_n = 1;
        clr = 0;
        check("s5_flag", int'(tempdrop), 1);
        check("s5_cnt", int'(drop_cnt), 1);

        // 6: reset at settle tick 5
        heaten_n = 0;
        steps(8);
        heaten_n = 1;
        wait_settle();
        run_ticks(5);
        rst = 1;
        step();
        check_reset_outputs("s6");
        rst = 0;
        wait_settle();
        wait_ready(t);
        check("s6_ticks", t, 8);

        // randomized traffic with independent, non-aligned enables
        rand_mode = 1;
        for (int i = 0; i < 4000; i++) begin
            if (($urandom % 48) == 0) heaten_n = !heaten_n;
            set_n  = ($urandom % 12) != 0;
            clr    = ($urandom % 20) == 0;
            stop_n = ($urandom % 6) != 0;
            if (($urandom % 40) == 0) irq_en = !irq_en;
            rst    = ($urandom % 700) == 0;
            step();
        end
        rst = 0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
